// File: rtl/pool_stream.sv
// Streaming POOLxPOOL max/average pooling over a raster-scanned feature map.
// Non-overlapping windows (stride = POOL), valid/ready on both sides, one output register.
module pool_stream #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int POOL   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_last,
  output logic                     busy
);

  // state | meaning
  // IDLE  | no frame in flight, counters at 0
  // RUN   | frame in progress, mode_q governs arithmetic
  // DONE  | whole frame accepted, waiting for the final result to transfer

  localparam int LP    = (POOL == 4) ? 2 : 1;
  localparam int SH    = 2 * LP;
  localparam int ACC_W = DATA_W + SH;
  localparam int NOC   = IMG_W / POOL;
  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int OCW   = (NOC > 1) ? $clog2(NOC) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic [LP-1:0]  wc, wr;
  logic [OCW-1:0] oc;
  logic           mode_q;
  logic           cur_mode;
  logic           accept;
  logic           col_last, row_last, frame_end;
  logic           emit;
  logic           last_xfer;

  logic signed [ACC_W-1:0] h_acc;
  logic signed [ACC_W-1:0] px_ext;
  logic signed [ACC_W-1:0] r;
  logic signed [ACC_W-1:0] fin;
  logic signed [ACC_W-1:0] row_buf [NOC];

  function automatic logic signed [ACC_W-1:0] comb_op(
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b,
    input logic                    avg
  );
    if (avg) return a + b;
    return (a > b) ? a : b;
  endfunction

  assign wc = col[LP-1:0];
  assign wr = row[LP-1:0];
  assign oc = OCW'(col >> LP);

  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign busy      = (state != S_IDLE);
  // The first pixel of a frame (from IDLE or DONE) uses the live mode input.
  assign cur_mode  = (state == S_RUN) ? mode_q : mode;

  assign col_last  = (col == CW'(IMG_W - 1));
  assign row_last  = (row == RW'(IMG_H - 1));
  assign frame_end = accept && col_last && row_last;
  assign emit      = accept && (wc == '1) && (wr == '1);
  assign last_xfer = out_valid && out_ready && out_last;

  assign px_ext = {{SH{in_data[DATA_W-1]}}, in_data};
  assign r      = comb_op(h_acc, px_ext, cur_mode);
  assign fin    = comb_op(row_buf[oc], r, cur_mode);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (accept) state_n = S_RUN;
      S_RUN:  if (frame_end) state_n = S_DONE;
      S_DONE: if (last_xfer) state_n = accept ? S_RUN : S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      mode_q    <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      if (accept) begin
        if (state != S_RUN) mode_q <= mode;
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (emit) begin
        out_valid <= 1'b1;
        out_last  <= frame_end;
        // Average: arithmetic shift by SH then truncate is exactly the top DATA_W bits.
        out_data  <= cur_mode ? fin[ACC_W-1:SH] : fin[DATA_W-1:0];
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  // Datapath needs no reset: every entry is rewritten at wc/wr = 0 before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (wc == '0)      h_acc <= px_ext;
      else if (wc != '1) h_acc <= r;
      if (wc == '1) begin
        if (wr == '0)      row_buf[oc] <= r;
        else if (wr != '1) row_buf[oc] <= fin;
      end
    end
  end

endmodule
